elevator_dispatcher: RTL and testbench
======================================

ELEVATOR_DISPATCHER -- requirements
Module: elevator_dispatcher

Interface
REQ-001 SHALL have parameter FLOORS, default 12, number of floors / hall-call bits.
REQ-002 SHALL have parameter CARS, default 4, number of elevator cars.
REQ-003 SHALL have parameter FW, default 4, floor-index width.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sim_state  in  2  00 stopped, 01 running, 10 paused, 11 clear.
REQ-007 SHALL have port floors_requested  in  FLOORS  level hall calls, bit i = floor i.
REQ-008 SHALL have port elevator_states  in  2*CARS  per car [2c+1:2c]: 00 idle, 01 up, 10 down, 11 doors open.
REQ-009 SHALL have port car_floors  in  FW*CARS  current floor per car, [FW*c+FW-1:FW*c].
REQ-010 SHALL have port dispatch_ready  in  CARS  per-car accept of an assignment.
REQ-011 SHALL have port dispatch_valid  out  CARS  one-hot assignment strobe.
REQ-012 SHALL have port dispatch_floor  out  FW  target floor of current assignment.
REQ-013 SHALL have port pending  out  FLOORS  unserviced hall calls.
REQ-014 SHALL have port busy  out  1  high whenever FSM is not IDLE.

Function
REQ-015 SHALL OR floors_requested into pending every cycle, including paused/stopped; set wins over same-cycle clear.
REQ-016 SHALL implement FSM IDLE, SCAN, SELECT, ISSUE.
REQ-017 IDLE -> SCAN when sim_state==01 and pending!=0.
REQ-018 SCAN: latch target = first set pending bit at or above pointer, wrapping FLOORS-1 -> 0; -> SELECT.
REQ-019 SELECT: available car = state 00 and reserved bit clear; if any -> ISSUE with car latched; else hold SELECT.
REQ-020 ISSUE: drive dispatch_valid[car]=1, dispatch_floor=target; on dispatch_ready[car]: clear pending[target], set reserved[car], pointer = (target+1) mod FLOORS, -> IDLE.
REQ-021 dispatch_valid SHALL never deassert in ISSUE without handshake except via REQ-025 or reset; dispatch_ready on non-selected cars ignored.
REQ-022 reserved[c] SHALL clear the first cycle elevator_states for car c is non-00.
REQ-023 Minimum latency: request sampled at edge N -> dispatch_valid high after edge N+4.
REQ-024 sim_state 10: FSM and pointer frozen (ISSUE outputs held); 00: SCAN/SELECT return to IDLE, ISSUE completes handshake.
REQ-025 sim_state 11: synchronously clear pending, reserved, pointer, FSM->IDLE, from any state including ISSUE.
REQ-026 dispatch_floor SHALL read 0 and dispatch_valid all-zero outside ISSUE.

Reset
REQ-027 rst low SHALL asynchronously force FSM IDLE, pending 0, reserved 0, pointer 0, dispatch_valid 0, dispatch_floor 0, busy 0.
REQ-028 Release SHALL be synchronous to clk; first transition no earlier than first edge with rst high.

Configuration
REQ-029 With ELEVATOR_NEAREST_CAR_EN defined, SELECT SHALL pick the available car minimizing |car_floor - target|, ties to lowest index.
REQ-030 Without ELEVATOR_NEAREST_CAR_EN, SELECT SHALL pick available cars round-robin, starting one past the last dispatched car (initially car 0).

Verification
REQ-031 Reset: rst low mid-ISSUE -> dispatch_valid 0, pending 0 immediately, no clock needed.
REQ-032 Single call: sim_state=01, all cars idle, floors_requested=12'h020 one cycle -> dispatch_floor=5, one-hot valid after 4 edges; ready -> pending=0, reserved car.
REQ-033 Wrap: pointer=10, pending bits 2 and 11 -> floor 11 dispatched first, then floor 2.
REQ-034 No car: elevator_states=8'b0101_0101 -> FSM holds SELECT, busy=1; car 0 to 00 -> assignment to car 0.
REQ-035 Nearest (macro on): car_floors {9,6,0,3}, target 7 -> car 2 (floor 6); macro off -> car 0.
REQ-036 Pause/clear: sim_state=10 during ISSUE -> outputs held; sim_state=11 -> IDLE, pending 0 next edge.

Source files
------------

// File: rtl/elevator_dispatcher.sv
// elevator_dispatcher: hall-call collector and car dispatcher.
// Latches hall calls into a pending vector. Scans the calls round-robin from a floor pointer.
// Picks an available car and hands the assignment over with a valid/ready handshake.
// Optional feature macro: ELEVATOR_NEAREST_CAR_EN.
//   Defined:   the car closest to the target floor is chosen (ties go to the lowest index).
//   Undefined: available cars are chosen round-robin.
module elevator_dispatcher #(
    parameter int FLOORS = 12,
    parameter int CARS   = 4,
    parameter int FW     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           sim_state,
    input  logic [FLOORS-1:0]    floors_requested,
    input  logic [2*CARS-1:0]    elevator_states,
    input  logic [FW*CARS-1:0]   car_floors,
    input  logic [CARS-1:0]      dispatch_ready,
    output logic [CARS-1:0]      dispatch_valid,
    output logic [FW-1:0]        dispatch_floor,
    output logic [FLOORS-1:0]    pending,
    output logic                 busy
);

    localparam int CW = (CARS > 1) ? $clog2(CARS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_SELECT = 2'd2,
        ST_ISSUE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [FLOORS-1:0]   pending_r;
    logic [CARS-1:0]     reserved_r;
    logic [FW-1:0]       pointer_r;
    logic [FW-1:0]       target_r;
    logic [CW-1:0]       car_r;
    logic [CARS-1:0]     valid_r;
    logic [FW-1:0]       floor_r;
    logic                busy_r;

    logic                sim_run_s;
    logic                sim_pause_s;
    logic                sim_clear_s;
    logic                scan_hit_s;
    logic [FW-1:0]       scan_floor_s;
    logic [CARS-1:0]     avail_s;
    logic [CARS-1:0]     moving_s;
    logic                pick_found_s;
    logic [CW-1:0]       pick_car_s;
    logic                handshake_s;
    logic [CARS-1:0]     car_onehot_s;
    logic [FLOORS-1:0]   target_onehot_s;

    // Returns {found, floor} for the first set bit at or above start, wrapping past the top floor.
    function automatic logic [FW:0] first_from(input logic [FLOORS-1:0] vec, input logic [FW-1:0] start);
        logic          found;
        logic [FW-1:0] pick;
        int            idx;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < FLOORS; i++) begin
            idx   = int'(start) + i;
            idx   = (idx >= FLOORS) ? (idx - FLOORS) : idx;
            pick  = (!found && vec[idx]) ? FW'(idx) : pick;
            found = found | vec[idx];
        end
        return {found, pick};
    endfunction

    assign sim_run_s       = (sim_state == 2'b01);
    assign sim_pause_s     = (sim_state == 2'b10);
    assign sim_clear_s     = (sim_state == 2'b11);
    assign car_onehot_s    = {{(CARS-1){1'b0}}, 1'b1} << car_r;
    assign target_onehot_s = {{(FLOORS-1){1'b0}}, 1'b1} << target_r;
    assign handshake_s     = (state_r == ST_ISSUE) && (valid_r != '0) && dispatch_ready[car_r]
                             && !sim_pause_s && !sim_clear_s;
    assign {scan_hit_s, scan_floor_s} = first_from(pending_r, pointer_r);

    // Per-car availability: idle and not already holding an unconsumed assignment.
    always_comb begin
        avail_s  = '0;
        moving_s = '0;
        for (int c = 0; c < CARS; c++) begin
            moving_s[c] = (elevator_states[2*c +: 2] != 2'b00);
            avail_s[c]  = !moving_s[c] && !reserved_r[c];
        end
    end

`ifdef ELEVATOR_NEAREST_CAR_EN
    // Nearest-car pick: smallest floor distance to the target; a strict compare keeps ties on the lowest index.
    always_comb begin
        logic [FW-1:0] best;
        logic [FW-1:0] dist;
        logic [FW-1:0] cf;
        logic          take;
        pick_found_s = 1'b0;
        pick_car_s   = '0;
        best         = '0;
        for (int c = 0; c < CARS; c++) begin
            cf           = car_floors[FW*c +: FW];
            dist         = (cf >= target_r) ? (cf - target_r) : (target_r - cf);
            take         = avail_s[c] && (!pick_found_s || (dist < best));
            best         = take ? dist : best;
            pick_car_s   = take ? CW'(c) : pick_car_s;
            pick_found_s = pick_found_s | avail_s[c];
        end
    end
`else
    logic [CW-1:0] rr_r;
    logic          unused_floors_s;

    assign unused_floors_s = ^car_floors;

    // Round-robin pick: the first available car starting one past the last dispatched car.
    always_comb begin
        int  idx;
        pick_found_s = 1'b0;
        pick_car_s   = '0;
        for (int i = 0; i < CARS; i++) begin
            idx          = int'(rr_r) + i;
            idx          = (idx >= CARS) ? (idx - CARS) : idx;
            pick_car_s   = (!pick_found_s && avail_s[idx]) ? CW'(idx) : pick_car_s;
            pick_found_s = pick_found_s | avail_s[idx];
        end
    end

    // Round-robin start pointer advances past each car that accepts an assignment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_r <= '0;
        end else if (handshake_s) begin
            rr_r <= (int'(car_r) == CARS - 1) ? '0 : car_r + CW'(1);
        end else begin
            rr_r <= rr_r;
        end
    end
`endif

    // Next-state logic: clear beats everything, pause freezes, stop abandons SCAN/SELECT.
    always_comb begin
        state_s = state_r;
        if (sim_clear_s) begin
            state_s = ST_IDLE;
        end else if (sim_pause_s) begin
            state_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE:   state_s = (sim_run_s && (pending_r != '0)) ? ST_SCAN : ST_IDLE;
                ST_SCAN:   state_s = (sim_run_s && scan_hit_s) ? ST_SELECT : ST_IDLE;
                ST_SELECT: state_s = !sim_run_s ? ST_IDLE : (pick_found_s ? ST_ISSUE : ST_SELECT);
                ST_ISSUE:  state_s = handshake_s ? ST_IDLE : ST_ISSUE;
                default:   state_s = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Hall-call capture: new calls are always ORed in, so a call arriving during a clear survives it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r <= '0;
        end else if (sim_clear_s) begin
            pending_r <= floors_requested;
        end else begin
            pending_r <= (pending_r & ~(handshake_s ? target_onehot_s : '0)) | floors_requested;
        end
    end

    // Reservation: set on accept, dropped as soon as the car reports any non-idle state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reserved_r <= '0;
        end else if (sim_clear_s) begin
            reserved_r <= '0;
        end else begin
            reserved_r <= (reserved_r & ~moving_s) | (handshake_s ? car_onehot_s : '0);
        end
    end

    // Scan pointer moves one past each serviced floor so calls are served fairly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pointer_r <= '0;
        end else if (sim_clear_s) begin
            pointer_r <= '0;
        end else if (handshake_s) begin
            pointer_r <= (target_r == FW'(FLOORS - 1)) ? '0 : target_r + FW'(1);
        end else begin
            pointer_r <= pointer_r;
        end
    end

    // Target floor and chosen car are latched on leaving SCAN and SELECT respectively.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target_r <= '0;
            car_r    <= '0;
        end else begin
            target_r <= ((state_r == ST_SCAN) && (state_s == ST_SELECT)) ? scan_floor_s : target_r;
            car_r    <= ((state_r == ST_SELECT) && (state_s == ST_ISSUE)) ? pick_car_s : car_r;
        end
    end

    // Registered outputs: the assignment shows from the second ISSUE cycle and drops with the handshake edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
            floor_r <= '0;
            busy_r  <= 1'b0;
        end else if (sim_clear_s) begin
            valid_r <= '0;
            floor_r <= '0;
            busy_r  <= 1'b0;
        end else if (sim_pause_s) begin
            valid_r <= valid_r;
            floor_r <= floor_r;
            busy_r  <= busy_r;
        end else begin
            valid_r <= ((state_r == ST_ISSUE) && (state_s == ST_ISSUE)) ? car_onehot_s : '0;
            floor_r <= ((state_r == ST_ISSUE) && (state_s == ST_ISSUE)) ? target_r : '0;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign dispatch_valid = valid_r;
    assign dispatch_floor = floor_r;
    assign pending        = pending_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed testbench for elevator_dispatcher with hand-computed expectations.
// The default build uses round-robin car selection.
// With ELEVATOR_NEAREST_CAR_EN defined, only the nearest-car vector changes.
module tb_elevator_dispatcher;

    logic        clk;
    logic        rst;
    logic [1:0]  sim_state;
    logic [11:0] floors_requested;
    logic [7:0]  elevator_states;
    logic [15:0] car_floors;
    logic [3:0]  dispatch_ready;
    logic [3:0]  dispatch_valid;
    logic [3:0]  dispatch_floor;
    logic [11:0] pending;
    logic        busy;

    int checks = 0;
    int errors = 0;

    elevator_dispatcher #(.FLOORS(12), .CARS(4), .FW(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .sim_state        (sim_state),
        .floors_requested (floors_requested),
        .elevator_states  (elevator_states),
        .car_floors       (car_floors),
        .dispatch_ready   (dispatch_ready),
        .dispatch_valid   (dispatch_valid),
        .dispatch_floor   (dispatch_floor),
        .pending          (pending),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while ((dispatch_valid == 4'b0000) && (n < 30)) begin
            tick();
            n++;
        end
        check_eq({tag, "_arrived"}, 32'(dispatch_valid != 4'b0000), 32'd1);
    endtask

    task automatic do_dispatch(input string tag, input logic [11:0] req,
                               input logic [3:0] exp_floor, input logic [3:0] exp_valid);
        floors_requested = req;
        tick();
        floors_requested = 12'h000;
        wait_valid(tag);
        check_eq({tag, "_floor"}, 32'(dispatch_floor), 32'(exp_floor));
        check_eq({tag, "_valid"}, 32'(dispatch_valid), 32'(exp_valid));
        dispatch_ready = exp_valid;
        tick();
        dispatch_ready = 4'b0000;
        check_eq({tag, "_done"}, 32'(dispatch_valid), 32'd0);
    endtask

    initial begin
        rst              = 1'b0;
        sim_state        = 2'b01;
        floors_requested = 12'hFFF;
        elevator_states  = 8'h00;
        car_floors       = 16'h0000;
        dispatch_ready   = 4'b0000;

        // Reset holds everything clear even with calls present.
        repeat (2) tick();
        check_eq("rst_valid",   32'(dispatch_valid), 32'd0);
        check_eq("rst_floor",   32'(dispatch_floor), 32'd0);
        check_eq("rst_pending", 32'(pending),        32'd0);
        check_eq("rst_busy",    32'(busy),           32'd0);
        floors_requested = 12'h000;
        rst = 1'b1;
        tick();

        // Single call to floor 5: valid rises after the fourth edge counted from the sampling edge.
        floors_requested = 12'h020;
        tick();
        floors_requested = 12'h000;
        check_eq("one_pending", 32'(pending), 32'h020);
        check_eq("one_busy0",   32'(busy),    32'd0);
        tick();
        check_eq("one_busy1",   32'(busy),    32'd1);
        tick();
        tick();
        check_eq("one_lat_n3",  32'(dispatch_valid), 32'd0);
        tick();
        check_eq("one_valid",   32'(dispatch_valid), 32'b0001);
        check_eq("one_floor",   32'(dispatch_floor), 32'd5);
        dispatch_ready = 4'b0010;
        tick();
        check_eq("one_other_rdy", 32'(dispatch_valid), 32'b0001);
        dispatch_ready = 4'b0001;
        tick();
        dispatch_ready = 4'b0000;
        check_eq("one_done_valid",   32'(dispatch_valid), 32'd0);
        check_eq("one_done_floor",   32'(dispatch_floor), 32'd0);
        check_eq("one_done_pending", 32'(pending),        32'd0);
        check_eq("one_done_busy",    32'(busy),           32'd0);

        // Floor 9 moves the pointer to 10; then the 11/2 pair must be served 11 first.
        do_dispatch("f9",  12'h200, 4'd9,  4'b0010);
        do_dispatch("f11", 12'h804, 4'd11, 4'b0100);
        check_eq("wrap_pending", 32'(pending), 32'h004);
        do_dispatch("f2",  12'h000, 4'd2,  4'b1000);

        // Release every reservation by having all cars leave idle for a cycle.
        elevator_states = 8'hFF;
        tick();
        elevator_states = 8'h00;
        tick();

        // Target 7 with cars at {9,6,0,3}.
        car_floors = 16'h9603;
`ifdef ELEVATOR_NEAREST_CAR_EN
        do_dispatch("near", 12'h080, 4'd7, 4'b0100);
`else
        do_dispatch("near", 12'h080, 4'd7, 4'b0001);
`endif
        car_floors = 16'h0000;

        // No idle car: SELECT holds with busy high until car 0 goes idle.
        elevator_states = 8'h55;
        tick();
        floors_requested = 12'h008;
        tick();
        floors_requested = 12'h000;
        repeat (8) tick();
        check_eq("nocar_valid", 32'(dispatch_valid), 32'd0);
        check_eq("nocar_busy",  32'(busy),           32'd1);
        elevator_states = 8'h54;
        wait_valid("nocar");
        check_eq("nocar_car",   32'(dispatch_valid), 32'b0001);
        check_eq("nocar_floor", 32'(dispatch_floor), 32'd3);
        dispatch_ready = 4'b0001;
        tick();
        dispatch_ready  = 4'b0000;
        elevator_states = 8'h00;
        check_eq("nocar_done",  32'(dispatch_valid), 32'd0);

        // Pause during ISSUE holds outputs, calls still accumulate; clear then drops everything.
        floors_requested = 12'h040;
        tick();
        floors_requested = 12'h000;
        wait_valid("pause");
        check_eq("pause_pre_valid", 32'(dispatch_valid), 32'b0010);
        sim_state        = 2'b10;
        floors_requested = 12'h002;
        tick();
        floors_requested = 12'h000;
        repeat (3) tick();
        check_eq("pause_valid",   32'(dispatch_valid), 32'b0010);
        check_eq("pause_floor",   32'(dispatch_floor), 32'd6);
        check_eq("pause_busy",    32'(busy),           32'd1);
        check_eq("pause_pending", 32'(pending),        32'h042);
        sim_state = 2'b11;
        tick();
        check_eq("clear_valid",   32'(dispatch_valid), 32'd0);
        check_eq("clear_floor",   32'(dispatch_floor), 32'd0);
        check_eq("clear_pending", 32'(pending),        32'd0);
        check_eq("clear_busy",    32'(busy),           32'd0);
        sim_state = 2'b01;
        tick();
        check_eq("clear_idle",    32'(busy),           32'd0);

        // Asynchronous reset in the middle of ISSUE, checked without any clock edge.
        floors_requested = 12'h100;
        tick();
        floors_requested = 12'h000;
        wait_valid("arst");
        check_eq("arst_pre_floor", 32'(dispatch_floor), 32'd8);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_valid",   32'(dispatch_valid), 32'd0);
        check_eq("arst_pending", 32'(pending),        32'd0);
        check_eq("arst_busy",    32'(busy),           32'd0);
        check_eq("arst_floor",   32'(dispatch_floor), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
